// File: rtl/dcache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_miss_ctrl
// Description : Data-cache control FSM: hits, store enables, dirty writeback,
//               multi-beat refill, round-robin victims, uncached accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_miss_ctrl #(
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_req_valid,
  input  logic                          i_req_op,
  input  logic                          i_req_uncached,
  input  logic                          i_hit,
  input  logic [$clog2(WAYS)-1:0]       i_hit_way,
  input  logic                          i_victim_dirty,
  input  logic                          i_rd_rdy,
  input  logic                          i_ret_valid,
  input  logic                          i_ret_last,
  input  logic                          i_wr_rdy,
  output logic                          o_stall,
  output logic                          o_resp_valid,
  output logic                          o_store_we,
  output logic [$clog2(WAYS)-1:0]       o_store_way,
  output logic                          o_rd_req,
  output logic                          o_rd_uncached,
  output logic                          o_wr_req,
  output logic                          o_wr_uncached,
  output logic [$clog2(WAYS)-1:0]       o_victim_way,
  output logic                          o_refill_we,
  output logic [$clog2(LINE_WORDS)-1:0] o_refill_idx,
  output logic                          o_tag_we,
  output logic                          o_protocol_err
);

  localparam int WAY_W = $clog2(WAYS);
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam logic [IDX_W-1:0] c_LAST_CACHED = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_RUN    = 3'd0,
    S_MISS   = 3'd1,
    S_WB     = 3'd2,
    S_RD     = 3'd3,
    S_REFILL = 3'd4,
    S_UCW    = 3'd5
  } state_t;

  state_t           r_state;
  logic [WAY_W-1:0] r_victim_ptr;
  logic [IDX_W-1:0] r_beat_cnt;
  logic             r_protocol_err;
  logic             r_uncached;

  state_t           w_next;
  logic             w_stall;
  logic             w_resp_valid;
  logic             w_store_we;
  logic [WAY_W-1:0] w_store_way;
  logic             w_rd_req;
  logic             w_rd_uncached;
  logic             w_wr_req;
  logic             w_wr_uncached;
  logic             w_refill_we;
  logic [IDX_W-1:0] w_refill_idx;
  logic             w_tag_we;
  logic             w_beat_err;
  logic [IDX_W-1:0] w_last_idx;

  assign w_last_idx = r_uncached ? '0 : c_LAST_CACHED;

  always_comb begin
    w_next        = r_state;
    w_stall       = 1'b0;
    w_resp_valid  = 1'b0;
    w_store_we    = 1'b0;
    w_store_way   = '0;
    w_rd_req      = 1'b0;
    w_rd_uncached = 1'b0;
    w_wr_req      = 1'b0;
    w_wr_uncached = 1'b0;
    w_refill_we   = 1'b0;
    w_refill_idx  = '0;
    w_tag_we      = 1'b0;
    w_beat_err    = 1'b0;
    case (r_state)
      S_RUN: begin
        if (i_req_valid) begin
          if (i_req_uncached) begin
            w_stall = 1'b1;
            w_next  = i_req_op ? S_UCW : S_RD;
          end else if (i_hit) begin
            w_resp_valid = 1'b1;
            w_store_we   = i_req_op;
            w_store_way  = i_req_op ? i_hit_way : '0;
          end else begin
            w_stall = 1'b1;
            w_next  = S_MISS;
          end
        end
      end
      S_MISS: begin
        w_stall = 1'b1;
        w_next  = i_victim_dirty ? S_WB : S_RD;
      end
      S_WB: begin
        w_stall  = 1'b1;
        w_wr_req = 1'b1;
        if (i_wr_rdy) w_next = S_RD;
      end
      S_RD: begin
        w_stall       = 1'b1;
        w_rd_req      = 1'b1;
        w_rd_uncached = r_uncached;
        if (i_rd_rdy) w_next = S_REFILL;
      end
      S_REFILL: begin
        w_stall      = 1'b1;
        w_refill_idx = r_beat_cnt;
        if (i_ret_valid) begin
          w_refill_we = ~r_uncached;
          // Early last and missing last are both protocol violations.
          w_beat_err  = i_ret_last != (r_beat_cnt == w_last_idx);
          if (i_ret_last) begin
            w_next = S_RUN;
            if (r_uncached) begin
              w_resp_valid = 1'b1;
              w_stall      = 1'b0;
            end else begin
              w_tag_we = 1'b1;
            end
          end
        end
      end
      S_UCW: begin
        w_stall       = 1'b1;
        w_wr_req      = 1'b1;
        w_wr_uncached = 1'b1;
        if (i_wr_rdy) begin
          w_resp_valid = 1'b1;
          w_stall      = 1'b0;
          w_next       = S_RUN;
        end
      end
      default: w_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_RUN;
      r_victim_ptr   <= '0;
      r_beat_cnt     <= '0;
      r_protocol_err <= 1'b0;
      r_uncached     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_RUN && i_req_valid) r_uncached <= i_req_uncached;
      if (r_state == S_RD && i_rd_rdy) begin
        r_beat_cnt <= '0;
      end else if (r_state == S_REFILL && i_ret_valid) begin
        r_beat_cnt <= r_beat_cnt + IDX_W'(1);
      end
      if (w_tag_we) r_victim_ptr <= r_victim_ptr + WAY_W'(1);
      if (w_beat_err) r_protocol_err <= 1'b1;
    end
  end

  // Outputs are forced quiet while reset is held, whatever the inputs do.
  assign o_stall        = w_stall & ~rst;
  assign o_resp_valid   = w_resp_valid & ~rst;
  assign o_store_we     = w_store_we & ~rst;
  assign o_store_way    = rst ? '0 : w_store_way;
  assign o_rd_req       = w_rd_req & ~rst;
  assign o_rd_uncached  = w_rd_uncached & ~rst;
  assign o_wr_req       = w_wr_req & ~rst;
  assign o_wr_uncached  = w_wr_uncached & ~rst;
  assign o_victim_way   = r_victim_ptr;
  assign o_refill_we    = w_refill_we & ~rst;
  assign o_refill_idx   = rst ? '0 : w_refill_idx;
  assign o_tag_we       = w_tag_we & ~rst;
  assign o_protocol_err = r_protocol_err;

endmodule
`default_nettype wire

// File: tb/tb_dcache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_miss_ctrl
// Description : Directed self-checking bench for dcache_miss_ctrl (2 ways, 4 words).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_miss_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_req_valid, i_req_op, i_req_uncached, i_hit;
  logic [0:0] i_hit_way;
  logic       i_victim_dirty, i_rd_rdy, i_ret_valid, i_ret_last, i_wr_rdy;
  logic       o_stall, o_resp_valid, o_store_we;
  logic [0:0] o_store_way;
  logic       o_rd_req, o_rd_uncached, o_wr_req, o_wr_uncached;
  logic [0:0] o_victim_way;
  logic       o_refill_we;
  logic [1:0] o_refill_idx;
  logic       o_tag_we, o_protocol_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dcache_miss_ctrl #(.WAYS(2), .LINE_WORDS(4)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .i_req_valid    (i_req_valid),
    .i_req_op       (i_req_op),
    .i_req_uncached (i_req_uncached),
    .i_hit          (i_hit),
    .i_hit_way      (i_hit_way),
    .i_victim_dirty (i_victim_dirty),
    .i_rd_rdy       (i_rd_rdy),
    .i_ret_valid    (i_ret_valid),
    .i_ret_last     (i_ret_last),
    .i_wr_rdy       (i_wr_rdy),
    .o_stall        (o_stall),
    .o_resp_valid   (o_resp_valid),
    .o_store_we     (o_store_we),
    .o_store_way    (o_store_way),
    .o_rd_req       (o_rd_req),
    .o_rd_uncached  (o_rd_uncached),
    .o_wr_req       (o_wr_req),
    .o_wr_uncached  (o_wr_uncached),
    .o_victim_way   (o_victim_way),
    .o_refill_we    (o_refill_we),
    .o_refill_idx   (o_refill_idx),
    .o_tag_we       (o_tag_we),
    .o_protocol_err (o_protocol_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the edge; checks happen 3ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic beat(input logic valid, input logic last);
    i_ret_valid = valid;
    i_ret_last  = last;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_req_valid = 1'b1; i_req_op = 1'b0; i_req_uncached = 1'b0; i_hit = 1'b1;
    i_hit_way = 1'b0; i_victim_dirty = 1'b0; i_rd_rdy = 1'b0; i_wr_rdy = 1'b0;
    beat(1'b0, 1'b0);
    step(); step();
    settle();
    chk("rst_resp",  o_resp_valid, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_vway",  o_victim_way, 0);
    chk("rst_err",   o_protocol_err, 0);

    // cached load hit
    step(); rst = 1'b0; settle();
    chk("ld_hit_resp",  o_resp_valid, 1);
    chk("ld_hit_stall", o_stall, 0);
    chk("ld_hit_rdreq", o_rd_req, 0);
    chk("ld_hit_swe",   o_store_we, 0);

    // store hit way 1
    step(); i_req_op = 1'b1; i_hit_way = 1'b1; settle();
    chk("st_hit_we",   o_store_we, 1);
    chk("st_hit_way",  o_store_way, 1);
    chk("st_hit_resp", o_resp_valid, 1);
    step(); i_req_valid = 1'b0; settle();
    chk("idle_swe",   o_store_we, 0);
    chk("idle_stall", o_stall, 0);

    // clean miss, rd_rdy on 3rd RD cycle, beats with gaps
    step(); i_req_valid = 1'b1; i_req_op = 1'b0; i_hit = 1'b0; i_hit_way = 1'b0; settle();
    chk("cm_run_stall", o_stall, 1);
    chk("cm_run_resp",  o_resp_valid, 0);
    step(); settle();
    chk("cm_miss_stall", o_stall, 1);
    chk("cm_miss_rdreq", o_rd_req, 0);
    step(); settle();
    chk("cm_rd1", o_rd_req, 1);
    chk("cm_rd1_unc", o_rd_uncached, 0);
    step(); settle();
    chk("cm_rd2", o_rd_req, 1);
    step(); i_rd_rdy = 1'b1; settle();
    chk("cm_rd3", o_rd_req, 1);
    step(); i_rd_rdy = 1'b0; beat(1, 0); settle();
    chk("cm_b0_we", o_refill_we, 1);
    chk("cm_b0_idx", o_refill_idx, 0);
    chk("cm_b0_rdreq", o_rd_req, 0);
    step(); beat(0, 0); settle();
    chk("cm_gap_we", o_refill_we, 0);
    chk("cm_gap_stall", o_stall, 1);
    step(); beat(1, 0); settle();
    chk("cm_b1_idx", o_refill_idx, 1);
    step(); beat(1, 0); settle();
    chk("cm_b2_idx", o_refill_idx, 2);
    chk("cm_b2_tagwe", o_tag_we, 0);
    step(); beat(0, 0); settle();
    chk("cm_gap2_we", o_refill_we, 0);
    step(); beat(1, 1); settle();
    chk("cm_b3_idx", o_refill_idx, 3);
    chk("cm_b3_we", o_refill_we, 1);
    chk("cm_b3_tagwe", o_tag_we, 1);
    chk("cm_b3_resp", o_resp_valid, 0);
    chk("cm_b3_vway", o_victim_way, 0);
    step(); beat(0, 0); i_hit = 1'b1; settle();
    chk("cm_relook_resp", o_resp_valid, 1);
    chk("cm_vway_adv", o_victim_way, 1);
    chk("cm_err", o_protocol_err, 0);

    // dirty miss, wr_rdy on 4th WB cycle
    step(); i_hit = 1'b0; i_victim_dirty = 1'b1; settle();
    chk("dm_run_stall", o_stall, 1);
    step(); settle();
    chk("dm_miss_wrreq", o_wr_req, 0);
    for (int i = 0; i < 4; i++) begin
      step(); i_wr_rdy = (i == 3); settle();
      chk("dm_wb_req", o_wr_req, 1);
      chk("dm_wb_unc", o_wr_uncached, 0);
      chk("dm_wb_vway", o_victim_way, 1);
    end
    step(); i_wr_rdy = 1'b0; i_victim_dirty = 1'b0; i_rd_rdy = 1'b1; settle();
    chk("dm_rd_req", o_rd_req, 1);
    chk("dm_rd_wrreq", o_wr_req, 0);
    step(); i_rd_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(1, i == 3); settle();
      chk("dm_idx", o_refill_idx, i);
      chk("dm_tagwe", o_tag_we, (i == 3));
      step();
    end
    beat(0, 0); i_hit = 1'b1; settle();
    chk("dm_relook_resp", o_resp_valid, 1);
    chk("dm_vway_wrap", o_victim_way, 0);

    // uncached load, single beat
    step(); i_req_uncached = 1'b1; settle();
    chk("ul_run_stall", o_stall, 1);
    chk("ul_run_resp", o_resp_valid, 0);
    step(); i_rd_rdy = 1'b1; settle();
    chk("ul_rd_req", o_rd_req, 1);
    chk("ul_rd_unc", o_rd_uncached, 1);
    step(); i_rd_rdy = 1'b0; beat(1, 1); settle();
    chk("ul_resp", o_resp_valid, 1);
    chk("ul_stall", o_stall, 0);
    chk("ul_refwe", o_refill_we, 0);
    chk("ul_tagwe", o_tag_we, 0);
    step(); beat(0, 0); i_req_valid = 1'b0; settle();
    chk("ul_err", o_protocol_err, 0);
    chk("ul_vway", o_victim_way, 0);

    // uncached store
    step(); i_req_valid = 1'b1; i_req_op = 1'b1; settle();
    chk("us_run_stall", o_stall, 1);
    step(); settle();
    chk("us_wr_req", o_wr_req, 1);
    chk("us_wr_unc", o_wr_uncached, 1);
    chk("us_wait_resp", o_resp_valid, 0);
    step(); i_wr_rdy = 1'b1; settle();
    chk("us_resp", o_resp_valid, 1);
    chk("us_stall", o_stall, 0);
    step(); i_wr_rdy = 1'b0; i_req_valid = 1'b0; settle();
    chk("us_idle_wrreq", o_wr_req, 0);

    // cached refill with early ret_last on beat index 2
    step(); i_req_valid = 1'b1; i_req_op = 1'b0; i_req_uncached = 1'b0; i_hit = 1'b0; settle();
    step(); settle();
    step(); i_rd_rdy = 1'b1; settle();
    step(); i_rd_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat(1, i == 2); settle();
      chk("pe_idx", o_refill_idx, i);
      step();
    end
    beat(0, 0); i_req_valid = 1'b0; settle();
    chk("pe_err_set", o_protocol_err, 1);
    chk("pe_vway", o_victim_way, 1);
    step(); settle();
    chk("pe_err_sticky", o_protocol_err, 1);

    // new miss, then reset mid-refill
    step(); i_req_valid = 1'b1; settle();
    step(); settle();
    step(); i_rd_rdy = 1'b1; settle();
    step(); i_rd_rdy = 1'b0; beat(1, 0); settle();
    chk("pr_b0_idx", o_refill_idx, 0);
    chk("pr_err_held", o_protocol_err, 1);
    step(); beat(1, 0); settle();
    chk("pr_b1_idx", o_refill_idx, 1);
    rst = 1'b1; #1;
    chk("pr_rst_stall", o_stall, 0);
    chk("pr_rst_refwe", o_refill_we, 0);
    chk("pr_rst_idx", o_refill_idx, 0);
    chk("pr_rst_err", o_protocol_err, 0);
    chk("pr_rst_vway", o_victim_way, 0);
    step(); rst = 1'b0; beat(0, 0); i_hit = 1'b1; settle();
    chk("pr_after_resp", o_resp_valid, 1);
    chk("pr_after_stall", o_stall, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
